// File: rtl/sif_initiator.sv
// sif bus initiator: queues X/W port commands and replays them as single-cycle
// strobes, returning X-port read data through a one-entry response slot.
module sif_initiator #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          xa_wr_s,
    output logic          xa_rd_s,
    output logic [AW-1:0] xa_addr,
    output logic [DW-1:0] xa_data_wr,
    input  logic [DW-1:0] xa_data_rd,
    output logic          wa_wr_s,
    output logic [AW-1:0] wa_addr,
    output logic [DW-1:0] wa_data_wr,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    input  logic          rsp_ready,
    output logic          busy,
    output logic          err_op
);

    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int PW = IW + 1;

    localparam logic [1:0] OP_XWR = 2'b00;
    localparam logic [1:0] OP_XRD = 2'b01;
    localparam logic [1:0] OP_WWR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state, state_d;

    logic [1:0]    fifo_op   [FIFO_DEPTH];
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          ready_en;
    logic          full, empty, push, pop;
    logic [1:0]    head_op;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    logic [2:0]    rd_cnt, rd_cnt_d;
    logic          go_xwr, go_xrd, go_wwr, set_err, capture;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

    assign cmd_ready = ready_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = !empty || (state != IDLE);

    assign head_op   = fifo_op[rd_ptr[IW-1:0]];
    assign head_addr = fifo_addr[rd_ptr[IW-1:0]];
    assign head_data = fifo_data[rd_ptr[IW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr[IW-1:0]]   <= cmd_op;
            fifo_addr[wr_ptr[IW-1:0]] <= cmd_addr;
            fifo_data[wr_ptr[IW-1:0]] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_comb begin
        state_d  = state;
        rd_cnt_d = rd_cnt;
        pop      = 1'b0;
        go_xwr   = 1'b0;
        go_xrd   = 1'b0;
        go_wwr   = 1'b0;
        set_err  = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_d = ISSUE;
            end
            ISSUE: begin
                if (empty) begin
                    state_d = IDLE;
                end else begin
                    case (head_op)
                        OP_XWR: begin
                            pop    = 1'b1;
                            go_xwr = 1'b1;
                        end
                        OP_WWR: begin
                            pop    = 1'b1;
                            go_wwr = 1'b1;
                        end
                        OP_RSV: begin
                            pop     = 1'b1;
                            set_err = 1'b1;
                        end
                        OP_XRD: begin
                            // A read may only start if its response has somewhere to land.
                            if (!rsp_valid || rsp_ready) begin
                                pop      = 1'b1;
                                go_xrd   = 1'b1;
                                rd_cnt_d = '0;
                                state_d  = WAIT_RD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_RD: begin
                if (rd_cnt == 3'(RD_LAT)) begin
                    capture = 1'b1;
                    state_d = empty ? IDLE : ISSUE;
                end else begin
                    rd_cnt_d = rd_cnt + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            rd_cnt <= '0;
        end else begin
            state  <= state_d;
            rd_cnt <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            xa_wr_s    <= 1'b0;
            xa_rd_s    <= 1'b0;
            wa_wr_s    <= 1'b0;
            xa_addr    <= '0;
            xa_data_wr <= '0;
            wa_addr    <= '0;
            wa_data_wr <= '0;
            err_op     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            xa_wr_s <= go_xwr;
            xa_rd_s <= go_xrd;
            wa_wr_s <= go_wwr;
            if (go_xwr || go_xrd) xa_addr <= head_addr;
            if (go_xwr) xa_data_wr <= head_data;
            if (go_wwr) begin
                wa_addr    <= head_addr;
                wa_data_wr <= head_data;
            end
            if (set_err) err_op <= 1'b1;
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= xa_data_rd;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sif_initiator.sv
// Directed bench for sif_initiator with a small X-port memory responder and a strobe log.
module tb_sif_initiator;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        xa_wr_s, xa_rd_s, wa_wr_s;
    logic [15:0] xa_addr, xa_data_wr, xa_data_rd;
    logic [15:0] wa_addr, wa_data_wr;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_ready;
    logic        busy;
    logic        err_op;

    always #5 clk = ~clk;

    sif_initiator #(
        .AW(16), .DW(16), .FIFO_DEPTH(4), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
        .xa_data_wr(xa_data_wr), .xa_data_rd(xa_data_rd),
        .wa_wr_s(wa_wr_s), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy), .err_op(err_op)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] cyc;
    } ev_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          multi_strobe = 0;
    logic [15:0] mem [256];
    ev_t         evq [$];
    ev_t         mon_ev;
    int          mon_n;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log plus a simple X-port memory that answers reads in the strobe cycle.
    always @(negedge clk) begin
        mon_n = int'(xa_wr_s) + int'(xa_rd_s) + int'(wa_wr_s);
        if (mon_n > 1) multi_strobe++;
        if (xa_wr_s) begin
            mon_ev.kind = 2'd0; mon_ev.addr = xa_addr; mon_ev.data = xa_data_wr; mon_ev.cyc = cyc;
            evq.push_back(mon_ev);
            mem[xa_addr[7:0]] = xa_data_wr;
        end
        if (xa_rd_s) begin
            mon_ev.kind = 2'd1; mon_ev.addr = xa_addr; mon_ev.data = 16'h0; mon_ev.cyc = cyc;
            evq.push_back(mon_ev);
            xa_data_rd = mem[xa_addr[7:0]];
        end
        if (wa_wr_s) begin
            mon_ev.kind = 2'd2; mon_ev.addr = wa_addr; mon_ev.data = wa_data_wr; mon_ev.cyc = cyc;
            evq.push_back(mon_ev);
        end
        if (rsp_valid && rsp_ready) rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int idx, input logic [1:0] k,
                          input logic [15:0] a, input logic [15:0] d);
        if (idx < evq.size()) begin
            chk({tag, "_kind"}, 32'(evq[idx].kind), 32'(k));
            chk({tag, "_addr"}, 32'(evq[idx].addr), 32'(a));
            chk({tag, "_data"}, 32'(evq[idx].data), 32'(d));
        end else begin
            chk({tag, "_missing"}, evq.size(), idx + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                        output int acc);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && g < 100) begin
            tick();
            g++;
        end
        if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 1);
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        tick();
        while (busy && g < 300) begin
            tick();
            g++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          acc, a0, base, r0, g;
        logic [15:0] t1d [3];
        logic [1:0]  k;
        logic [15:0] d;
        ev_t         expq [$];
        ev_t         e;

        t1d[0] = 16'hA5A5; t1d[1] = 16'h5A5A; t1d[2] = 16'hFFFF;
        rst_b = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({xa_wr_s, xa_rd_s, wa_wr_s}), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_err_op", 32'(err_op), 0);
        rst_b = 1'b1;
        #1;
        chk("ready_at_release", 32'(cmd_ready), 0);
        tick();
        chk("ready_after_release", 32'(cmd_ready), 1);

        // Three back-to-back X writes
        base = evq.size();
        send(2'b00, 16'h0010, 16'hA5A5, a0);
        send(2'b00, 16'h0011, 16'h5A5A, acc);
        send(2'b00, 16'h0012, 16'hFFFF, acc);
        wait_idle();
        chk("t1_count", evq.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk_ev("t1_ev", base + i, 2'd0, 16'h0010 + 16'(i), t1d[i]);
            if (base + i < evq.size()) chk("t1_cycle", evq[base + i].cyc, 32'(a0 + 2 + i));
        end

        // W write then X read of earlier data
        base = evq.size(); r0 = rsp_cnt;
        send(2'b10, 16'h0100, 16'h1234, acc);
        send(2'b01, 16'h0010, 16'h0000, acc);
        wait_idle();
        chk("t2_count", evq.size() - base, 2);
        chk_ev("t2_ww", base, 2'd2, 16'h0100, 16'h1234);
        chk_ev("t2_xr", base + 1, 2'd1, 16'h0010, 16'h0000);
        chk("t2_rsp_valid", 32'(rsp_valid), 1);
        chk("t2_rsp_data", 32'(rsp_data), 32'hA5A5);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("t2_rsp_cleared", 32'(rsp_valid), 0);
        repeat (3) tick();
        chk("t2_rsp_count", rsp_cnt - r0, 1);

        // Two reads with the response held off; FIFO fills behind the stalled read
        base = evq.size(); r0 = rsp_cnt;
        send(2'b01, 16'h0011, 16'h0000, acc);
        send(2'b01, 16'h0012, 16'h0000, acc);
        send(2'b00, 16'h0020, 16'h1111, acc);
        send(2'b00, 16'h0021, 16'h2222, acc);
        send(2'b00, 16'h0022, 16'h3333, acc);
        repeat (4) tick();
        chk("t3_full", 32'(cmd_ready), 0);
        chk("t3_rsp_valid", 32'(rsp_valid), 1);
        chk("t3_rsp_data", 32'(rsp_data), 32'h5A5A);
        chk("t3_one_read", evq.size() - base, 1);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 16'h0023; cmd_data = 16'h4444;
        repeat (3) tick();
        chk("t3_fifth_blocked", 32'(cmd_ready), 0);
        chk("t3_still_one_read", evq.size() - base, 1);
        chk("t3_rsp_data_stable", 32'(rsp_data), 32'h5A5A);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        g = 0;
        while (!cmd_ready && g < 20) begin
            tick();
            g++;
        end
        chk("t3_ready_back", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        wait_idle();
        chk("t3_count", evq.size() - base, 6);
        chk_ev("t3_xr0", base, 2'd1, 16'h0011, 16'h0000);
        chk_ev("t3_xr1", base + 1, 2'd1, 16'h0012, 16'h0000);
        chk_ev("t3_w0", base + 2, 2'd0, 16'h0020, 16'h1111);
        chk_ev("t3_w1", base + 3, 2'd0, 16'h0021, 16'h2222);
        chk_ev("t3_w2", base + 4, 2'd0, 16'h0022, 16'h3333);
        chk_ev("t3_w3", base + 5, 2'd0, 16'h0023, 16'h4444);
        chk("t3_rsp2_valid", 32'(rsp_valid), 1);
        chk("t3_rsp2_data", 32'(rsp_data), 32'hFFFF);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("t3_rsp_count", rsp_cnt - r0, 2);

        // Reserved opcode between two W writes
        chk("t4_err_before", 32'(err_op), 0);
        base = evq.size();
        send(2'b10, 16'h0200, 16'hAAAA, acc);
        send(2'b11, 16'h0000, 16'h0000, acc);
        send(2'b10, 16'h0201, 16'hBBBB, acc);
        wait_idle();
        chk("t4_count", evq.size() - base, 2);
        chk_ev("t4_w0", base, 2'd2, 16'h0200, 16'hAAAA);
        chk_ev("t4_w1", base + 1, 2'd2, 16'h0201, 16'hBBBB);
        chk("t4_err_set", 32'(err_op), 1);
        repeat (5) tick();
        chk("t4_err_sticky", 32'(err_op), 1);

        // Reset while a read is outstanding and writes are queued
        base = evq.size();
        send(2'b01, 16'h0010, 16'h0000, acc);
        send(2'b00, 16'h0030, 16'h0101, acc);
        send(2'b00, 16'h0031, 16'h0202, acc);
        send(2'b00, 16'h0032, 16'h0303, acc);
        chk("t5_busy_pre", 32'(busy), 1);
        chk("t5_read_issued", evq.size() - base, 1);
        rst_b = 1'b0;
        #1;
        chk("t5_strobes", 32'({xa_wr_s, xa_rd_s, wa_wr_s}), 0);
        chk("t5_xa_addr", 32'(xa_addr), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_cmd_ready", 32'(cmd_ready), 0);
        chk("t5_rsp_valid", 32'(rsp_valid), 0);
        chk("t5_err_op", 32'(err_op), 0);
        tick(); tick();
        rst_b = 1'b1;
        repeat (6) tick();
        chk("t5_no_rsp", 32'(rsp_valid), 0);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_no_strobes", evq.size() - base, 1);

        // Mixed writes with random gaps across pointer wrap
        base = evq.size();
        for (int i = 0; i < 11; i++) begin
            k = (i % 3 == 1) ? 2'd2 : 2'd0;
            d = 16'h2000 + 16'(i) * 16'h0111;
            repeat ($urandom_range(0, 2)) tick();
            send(k, 16'h0400 + 16'(i), d, acc);
            e.kind = k; e.addr = 16'h0400 + 16'(i); e.data = d; e.cyc = 0;
            expq.push_back(e);
        end
        wait_idle();
        chk("t6_count", evq.size() - base, 11);
        for (int i = 0; i < 11; i++) begin
            chk_ev("t6_ev", base + i, expq[i].kind, expq[i].addr, expq[i].data);
        end
        chk("one_strobe_per_cycle", multi_strobe, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/sif_initiator.md
Name: sif_initiator

Overview:
- Bus initiator that drives the sif X port (write/read) and W port (write-only) from a queued command stream.
- Owns the other end of the xw_if protocol: it generates wr_s/rd_s strobes, addr and data_wr, and captures data_rd.
- Sits between a sequencer/CPU-side command source and the sif responder; returns X-port read data on a response channel.

Parameters:
- AW, 16, address width of X and W ports
- DW, 16, data width of X and W ports
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
- RD_LAT, 1, cycles from rd_s sample edge to data_rd valid (1..4)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_b  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- cmd_op  input  2  00 X write, 01 X read, 10 W write, 11 reserved
- cmd_addr  input  AW  command address
- cmd_data  input  DW  write data (ignored for reads)
- xa_wr_s  output  1  X write strobe
- xa_rd_s  output  1  X read strobe
- xa_addr  output  AW  X address
- xa_data_wr  output  DW  X write data
- xa_data_rd  input  DW  X read data
- wa_wr_s  output  1  W write strobe
- wa_addr  output  AW  W address
- wa_data_wr  output  DW  W write data
- rsp_valid  output  1  read response available
- rsp_data  output  DW  read response data
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- busy  output  1  FIFO non-empty or state != IDLE
- err_op  output  1  sticky: reserved opcode was accepted

Behaviour:
- Reset (rst_b=0, async): all outputs 0, cmd_ready=0 while in reset, FIFO flushed, state IDLE, err_op cleared; in-flight read is discarded. One cycle after release, cmd_ready=1.
- cmd_ready = FIFO not full. Accepting into a full FIFO is impossible; a simultaneous push and pop with the FIFO full is not allowed (ready is already 0).
- All bus outputs are registered. Strobes are high for exactly one cycle per transfer; addr/data are held stable in that cycle. When strobes are low, addr/data hold their last value.
- At most one bus strobe (xa_wr_s, xa_rd_s, wa_wr_s) is high in any cycle.
- FSM states: IDLE, ISSUE, WAIT_RD.
  - IDLE -> ISSUE when FIFO is non-empty.
  - ISSUE pops the head and drives its strobe in the next cycle:
    - op 00: xa_wr_s=1.
    - op 10: wa_wr_s=1.
    - op 11: no strobe; set err_op; pop and continue.
    - op 01: issued only if the response slot is empty or is being drained this cycle (rsp_ready=1). Otherwise stall in ISSUE without popping. When issued, xa_rd_s=1 and go to WAIT_RD.
  - Back-to-back writes: one per cycle, no bubbles, while the FIFO is non-empty. With the FIFO empty, ISSUE -> IDLE.
  - WAIT_RD counts RD_LAT cycles after the rd_s cycle, then samples xa_data_rd into rsp_data, sets rsp_valid=1, and returns to ISSUE or IDLE. No new strobe is issued during WAIT_RD (one outstanding read max).
- Response slot is single-entry. rsp_valid clears on handshake. rsp_data is stable while rsp_valid=1 and rsp_ready=0.
- Command-to-strobe latency with the FIFO empty: command accepted at edge N, strobe high in cycle N+2.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. full when MSBs differ and low bits are equal.
- busy=1 from first accept until the last strobe/response capture completes.

Test Plan:
- Reset, then 3 X writes (addr 0x0010/0x0011/0x0012, data 0xA5A5/0x5A5A/0xFFFF) pushed on consecutive cycles -> xa_wr_s high 3 consecutive cycles with matching addr/data; first strobe 2 cycles after first accept; wa_wr_s and xa_rd_s stay 0.
- W write addr 0x0100 data 0x1234, then X read addr 0x0010 with RD_LAT=1 -> wa_wr_s pulse, then xa_rd_s pulse; rsp_valid=1 with rsp_data=0xA5A5 (value written earlier), exactly one response.
- Hold rsp_ready=0, issue 2 X reads -> second xa_rd_s is not issued until the first response is taken; FIFO fills to 4 and cmd_ready drops to 0 on the 5th offer; no response is lost.
- cmd_op=11 at addr 0x0000 between two W writes -> no strobe for it, err_op=1 and stays set, both W writes still appear back-to-back.
- Assert rst_b=0 mid-WAIT_RD with 3 commands queued -> outputs 0 immediately (asynchronously), busy=0, no rsp_valid after release, err_op=0.
- Push 2*FIFO_DEPTH+3 mixed writes with random cmd_valid gaps -> strobe sequence order equals command order across pointer wrap; none dropped or duplicated.
